regfile_readback_scanner: RTL and testbench

Read-side companion to the register-file sequencing FSM. That FSM writes a Fibonacci sequence into the 16-entry register file. This block walks read port A through R0..R15 and latches each value for the seven-segment display path. It also checks the values against the expected Fibonacci sequence and flags the first mismatch.

---
 rtl/regfile_readback_scanner.sv | 163 ++++++++++++++++
 tb/tb_regfile_readback_scanner.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_readback_scanner.sv
// Read-side scanner for the register file: walks port A over R0..R(NUM_REGS-1),
// latches each value for the display path and flags the first deviation from Fibonacci.
module regfile_readback_scanner #(
    parameter int DWELL_CYCLES = 150000000,
    parameter int NUM_REGS     = 16,
    parameter int ADDR_W       = 4,
    parameter int DATA_W       = 16
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Auto,
    input  logic              Step,
    input  logic              Check_En,
    output logic [ADDR_W-1:0] Reg_Read_A,
    input  logic [DATA_W-1:0] Reg_A,
    output logic [DATA_W-1:0] Display_Value,
    output logic [ADDR_W-1:0] Display_Index,
    output logic              Display_Valid,
    output logic              Busy,
    output logic              Done,
    output logic              Mismatch,
    output logic [ADDR_W-1:0] Mismatch_Index
);

    localparam int                CNT_W      = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_CAPTURE,
        S_SHOW,
        S_DONE
    } state_t;

    state_t            state_q,        state_d;
    logic [ADDR_W-1:0] index_q,        index_d;
    logic [DATA_W-1:0] disp_value_q,   disp_value_d;
    logic [ADDR_W-1:0] disp_index_q,   disp_index_d;
    logic              disp_valid_q,   disp_valid_d;
    logic              mismatch_q,     mismatch_d;
    logic [ADDR_W-1:0] mismatch_idx_q, mismatch_idx_d;
    logic [CNT_W-1:0]  dwell_q,        dwell_d;
    logic [DATA_W-1:0] exp_prev_q,     exp_prev_d;
    logic [DATA_W-1:0] exp_cur_q,      exp_cur_d;
    logic              step_used_q,    step_used_d;
    logic              advance;

    // NOTE: non-blocking assignments here so every register samples the pre-edge
    // values of the others, independent of statement order.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q        <= S_IDLE;
            index_q        <= '0;
            disp_value_q   <= '0;
            disp_index_q   <= '0;
            disp_valid_q   <= 1'b0;
            mismatch_q     <= 1'b0;
            mismatch_idx_q <= '0;
            dwell_q        <= '0;
            exp_prev_q     <= '0;
            exp_cur_q      <= DATA_W'(1);
            step_used_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            index_q        <= index_d;
            disp_value_q   <= disp_value_d;
            disp_index_q   <= disp_index_d;
            disp_valid_q   <= disp_valid_d;
            mismatch_q     <= mismatch_d;
            mismatch_idx_q <= mismatch_idx_d;
            dwell_q        <= dwell_d;
            exp_prev_q     <= exp_prev_d;
            exp_cur_q      <= exp_cur_d;
            step_used_q    <= step_used_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets its hold value first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_d        = state_q;
        index_d        = index_q;
        disp_value_d   = disp_value_q;
        disp_index_d   = disp_index_q;
        disp_valid_d   = disp_valid_q;
        mismatch_d     = mismatch_q;
        mismatch_idx_d = mismatch_idx_q;
        dwell_d        = dwell_q;
        exp_prev_d     = exp_prev_q;
        exp_cur_d      = exp_cur_q;
        step_used_d    = step_used_q;
        advance        = 1'b0;

        // A held Step re-arms only once it has been released.
        if (!Step) begin
            step_used_d = 1'b0;
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (Start) begin
                    state_d        = S_ADDR;
                    index_d        = '0;
                    mismatch_d     = 1'b0;
                    mismatch_idx_d = '0;
                    exp_prev_d     = '0;
                    exp_cur_d      = DATA_W'(1);
                    disp_valid_d   = 1'b0;
                end
            end
            S_ADDR: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                disp_value_d = Reg_A;
                disp_index_d = index_q;
                disp_valid_d = 1'b1;
                dwell_d      = '0;
                if (Check_En && !mismatch_q && (Reg_A != exp_cur_q)) begin
                    mismatch_d     = 1'b1;
                    mismatch_idx_d = index_q;
                end
                state_d = S_SHOW;
            end
            S_SHOW: begin
                if (Auto) begin
                    dwell_d = dwell_q + 1'b1;
                    advance = (dwell_q == DWELL_LAST);
                end else if (Step && !step_used_q) begin
                    advance     = 1'b1;
                    step_used_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (advance) begin
            exp_prev_d = exp_cur_q;
            exp_cur_d  = exp_prev_q + exp_cur_q;
            if (index_q == LAST_IDX) begin
                state_d = S_DONE;
            end else begin
                index_d = index_q + 1'b1;
                state_d = S_ADDR;
            end
        end
    end

    assign Reg_Read_A     = index_q;
    assign Display_Value  = disp_value_q;
    assign Display_Index  = disp_index_q;
    assign Display_Valid  = disp_valid_q;
    assign Busy           = (state_q == S_ADDR) || (state_q == S_CAPTURE) || (state_q == S_SHOW);
    assign Done           = (state_q == S_DONE);
    assign Mismatch       = mismatch_q;
    assign Mismatch_Index = mismatch_idx_q;

endmodule

// File: tb/tb_regfile_readback_scanner.sv
// Directed-plus-random bench for regfile_readback_scanner against a cycle-count
// reference model built from the Fibonacci sequence and the 6-cycle-per-register schedule.
module tb_regfile_readback_scanner;

    localparam int DWELL = 4;
    localparam int NREGS = 16;
    localparam int CYC   = DWELL + 2;
    localparam int SCAN  = NREGS * CYC;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        auto_mode;
    logic        step;
    logic        check_en;
    logic [3:0]  reg_read_a;
    logic [15:0] reg_a;
    logic [15:0] display_value;
    logic [3:0]  display_index;
    logic        display_valid;
    logic        busy;
    logic        done;
    logic        mismatch;
    logic [3:0]  mismatch_index;

    logic [15:0] regs [NREGS];
    logic [15:0] fib  [NREGS];

    int total = 0;
    int bad   = 0;

    regfile_readback_scanner #(
        .DWELL_CYCLES(DWELL),
        .NUM_REGS    (NREGS),
        .ADDR_W      (4),
        .DATA_W      (16)
    ) dut (
        .Clk           (clk),
        .Reset_n       (reset_n),
        .Start         (start),
        .Auto          (auto_mode),
        .Step          (step),
        .Check_En      (check_en),
        .Reg_Read_A    (reg_read_a),
        .Reg_A         (reg_a),
        .Display_Value (display_value),
        .Display_Index (display_index),
        .Display_Valid (display_valid),
        .Busy          (busy),
        .Done          (done),
        .Mismatch      (mismatch),
        .Mismatch_Index(mismatch_index)
    );

    assign reg_a = regs[reg_read_a];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string where);
        check({where, "_rd_addr"},  32'(reg_read_a),     0);
        check({where, "_value"},    32'(display_value),  0);
        check({where, "_index"},    32'(display_index),  0);
        check({where, "_valid"},    32'(display_valid),  0);
        check({where, "_busy"},     32'(busy),           0);
        check({where, "_done"},     32'(done),           0);
        check({where, "_mismatch"}, 32'(mismatch),       0);
        check({where, "_mis_idx"},  32'(mismatch_index), 0);
    endtask

    task automatic load_fib();
        for (int i = 0; i < NREGS; i++) regs[i] = fib[i];
    endtask

    // Full auto-mode scan checked every cycle; optionally pulses Start while busy.
    task automatic run_auto_scan(input string name, input int poke_c, input bit step_too);
        int m;
        int k;
        bit exp_mis;
        m = -1;
        if (check_en) begin
            for (int i = 0; i < NREGS; i++) begin
                if (m < 0 && regs[i] != fib[i]) m = i;
            end
        end
        auto_mode = 1'b1;
        start     = 1'b1;
        step      = step_too;
        @(negedge clk);
        step = 1'b0;
        for (int c = 1; c <= SCAN + 2; c++) begin
            start = (c == poke_c);
            @(negedge clk);
            k = (c >= 2) ? (c - 2) / CYC : 0;
            if (k > NREGS - 1) k = NREGS - 1;
            exp_mis = (m >= 0) && (c >= 2 + CYC * m);
            check($sformatf("%s_c%0d_valid", name, c), 32'(display_valid), (c >= 2) ? 1 : 0);
            if (c >= 2) begin
                check($sformatf("%s_c%0d_index", name, c), 32'(display_index), k);
                check($sformatf("%s_c%0d_value", name, c), 32'(display_value), 32'(regs[k]));
            end
            check($sformatf("%s_c%0d_rd_addr", name, c), 32'(reg_read_a),
                  (c / CYC > NREGS - 1) ? NREGS - 1 : c / CYC);
            check($sformatf("%s_c%0d_busy", name, c), 32'(busy), (c < SCAN) ? 1 : 0);
            check($sformatf("%s_c%0d_done", name, c), 32'(done), (c >= SCAN) ? 1 : 0);
            check($sformatf("%s_c%0d_mismatch", name, c), 32'(mismatch), 32'(exp_mis));
            check($sformatf("%s_c%0d_mis_idx", name, c), 32'(mismatch_index), exp_mis ? m : 0);
        end
        start = 1'b0;
    endtask

    initial begin
        int gap;
        fib[0] = 16'd1;
        fib[1] = 16'd1;
        for (int i = 2; i < NREGS; i++) fib[i] = fib[i-1] + fib[i-2];

        reset_n   = 1'b0;
        start     = 1'b0;
        auto_mode = 1'b1;
        step      = 1'b0;
        check_en  = 1'b1;
        load_fib();
        #2;
        check_reset_outputs("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("idle");

        // Clean Fibonacci scan with a Start pulse while busy at index 3.
        run_auto_scan("fib", 20, 1'b0);

        // First failure at R7 wins over R9 and any later random corruption.
        load_fib();
        regs[7] = 16'h0000;
        regs[9] = 16'h0001;
        regs[$urandom_range(10, 15)] = 16'($urandom);
        run_auto_scan("corrupt", -1, 1'b1);

        // Restart after DONE clears Mismatch; all-ones with checking off.
        check_en = 1'b0;
        for (int i = 0; i < NREGS; i++) regs[i] = 16'hFFFF;
        run_auto_scan("ones", -1, 1'b0);

        // Random contents, each register either correct or random.
        check_en = 1'b1;
        for (int i = 0; i < NREGS; i++) regs[i] = ($urandom_range(0, 1) == 1) ? fib[i] : 16'($urandom);
        run_auto_scan("random", -1, 1'b0);

        // Manual stepping: three pulses with random gaps, then Step held high.
        load_fib();
        auto_mode = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("man_start_valid", 32'(display_valid), 1);
        check("man_start_index", 32'(display_index), 0);
        for (int p = 1; p <= 3; p++) begin
            gap = $urandom_range(2, 6);
            repeat (gap) @(negedge clk);
            check($sformatf("man_hold%0d_index", p), 32'(display_index), p - 1);
            check($sformatf("man_hold%0d_rd_addr", p), 32'(reg_read_a), p - 1);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            repeat (2) @(negedge clk);
            check($sformatf("man_step%0d_index", p), 32'(display_index), p);
            check($sformatf("man_step%0d_value", p), 32'(display_value), 32'(fib[p]));
        end
        step = 1'b1;
        repeat (10) @(negedge clk);
        step = 1'b0;
        check("man_held_index", 32'(display_index), 4);
        repeat (3) @(negedge clk);
        check("man_after_index", 32'(display_index), 4);
        check("man_after_busy", 32'(busy), 1);

        // Switch to auto mid-scan and let it finish within a bounded wait.
        auto_mode = 1'b1;
        for (int i = 0; i < 200 && !done; i++) @(negedge clk);
        check("man_auto_done", 32'(done), 1);
        check("man_auto_last_index", 32'(display_index), NREGS - 1);
        check("man_auto_mismatch", 32'(mismatch), 0);

        // Asynchronous reset while R5 is on display, then a full rescan from R0.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2 + 5 * CYC + 1) @(negedge clk);
        check("pre_reset_index", 32'(display_index), 5);
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("post_reset");
        run_auto_scan("rescan", -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
